// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle between a word source and the PISO serializer.
// master = upstream word source / bit-rate owner, slave = the serializer itself.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             bit_en;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output data_in,
    output load_valid,
    output bit_en,
    input  load_ready,
    input  dout,
    input  dout_valid,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  data_in,
    input  load_valid,
    input  bit_en,
    output load_ready,
    output dout,
    output dout_valid,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out framer: accepts WIDTH-bit words on valid/ready and emits one
// bit per bit_en strobe, streaming back-to-back words with no idle bit between frames.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  piso_serializer_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frame_done_q, frame_done_d;

  logic             last_bit;
  logic             load_ready;
  logic             xfer;
  logic [WIDTH-1:0] shreg_shifted;

  // Ready is also raised on the final bit so the next word lands without a gap.
  assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST_CNT) && bus.bit_en;
  assign load_ready = (state_q == IDLE) || last_bit;
  assign xfer       = bus.load_valid && load_ready;

  always_comb begin
    shreg_shifted = '0;
    if (MSB_FIRST) begin
      shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          shreg_d = bus.data_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (bus.bit_en) begin
          if (cnt_q != LAST_CNT) begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            frame_done_d = 1'b1;
            if (bus.load_valid) begin
              shreg_d = bus.data_in;
              cnt_d   = '0;
            end else begin
              shreg_d = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Output bit comes straight from the register so the detector sees a glitch-free din.
  assign bus.dout       = (state_q == SHIFT) ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : 1'b0;
  assign bus.dout_valid = (state_q == SHIFT);
  assign bus.busy       = (state_q == SHIFT);
  assign bus.frame_done = frame_done_q;
  assign bus.load_ready = load_ready;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances share clk/reset.
module tb_piso_serializer;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) ma ();
  piso_serializer_if #(.WIDTH(W)) la ();

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (ma.slave)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (la.slave)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_a;
  logic [7:0] exp_b;
  logic [3:0] det_sr;
  int         det_hits;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the MSB-first instance and let combinational outputs settle.
  task automatic drive(input logic lv, input logic [7:0] d, input logic be);
    ma.load_valid = lv;
    ma.data_in    = d;
    ma.bit_en     = be;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    ma.load_valid = 1'b0;
    ma.data_in    = '0;
    ma.bit_en     = 1'b0;
    la.load_valid = 1'b0;
    la.data_in    = '0;
    la.bit_en     = 1'b0;
    step();
    step();
    chk("rst_dout", 32'(ma.dout), 32'd0);
    chk("rst_dout_valid", 32'(ma.dout_valid), 32'd0);
    chk("rst_busy", 32'(ma.busy), 32'd0);
    chk("rst_frame_done", 32'(ma.frame_done), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_ready", 32'(ma.load_ready), 32'd1);

    // Single 0x99 frame, bit_en tied high, plus a 1001 overlapping detector on dout.
    exp_a    = 8'b1001_1001;
    det_sr   = '0;
    det_hits = 0;
    drive(1'b1, 8'h99, 1'b1);
    chk("f1_accept_ready", 32'(ma.load_ready), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      step();
      drive(1'b0, 8'h00, 1'b1);
      chk($sformatf("f1_dout_c%0d", c), 32'(ma.dout), 32'(exp_a[8-c]));
      chk($sformatf("f1_dvalid_c%0d", c), 32'(ma.dout_valid), 32'd1);
      chk($sformatf("f1_ready_c%0d", c), 32'(ma.load_ready), (c == 8) ? 32'd1 : 32'd0);
      det_sr = {det_sr[2:0], ma.dout};
      if (det_sr == 4'b1001) det_hits++;
    end
    step();
    chk("f1_done_c9", 32'(ma.frame_done), 32'd1);
    chk("f1_busy_c9", 32'(ma.busy), 32'd0);
    chk("f1_dvalid_c9", 32'(ma.dout_valid), 32'd0);
    chk("f1_detector_hits", 32'(det_hits), 32'd2);
    step();
    chk("f1_done_c10", 32'(ma.frame_done), 32'd0);

    // Back-to-back: 0x99 then 0x12 held valid from cycle 1.
    exp_b = 8'b0001_0010;
    drive(1'b1, 8'h99, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      step();
      drive(1'b1, 8'h12, 1'b1);
      chk($sformatf("b2b_ready_c%0d", c), 32'(ma.load_ready), (c == 8) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_a_dout_c%0d", c), 32'(ma.dout), 32'(exp_a[8-c]));
    end
    for (int c = 9; c <= 16; c++) begin
      step();
      drive(1'b0, 8'h00, 1'b1);
      chk($sformatf("b2b_b_dout_c%0d", c), 32'(ma.dout), 32'(exp_b[16-c]));
      chk($sformatf("b2b_busy_c%0d", c), 32'(ma.busy), 32'd1);
      chk($sformatf("b2b_done_c%0d", c), 32'(ma.frame_done), (c == 9) ? 32'd1 : 32'd0);
    end
    step();
    chk("b2b_done_c17", 32'(ma.frame_done), 32'd1);
    chk("b2b_busy_c17", 32'(ma.busy), 32'd0);
    step();

    // LSB-first instance, word 0x01.
    la.load_valid = 1'b1;
    la.data_in    = 8'h01;
    la.bit_en     = 1'b1;
    #1;
    for (int c = 1; c <= 8; c++) begin
      step();
      la.load_valid = 1'b0;
      la.data_in    = 8'h00;
      #1;
      chk($sformatf("lsb_dout_c%0d", c), 32'(la.dout), (c == 1) ? 32'd1 : 32'd0);
    end
    step();
    chk("lsb_done_c9", 32'(la.frame_done), 32'd1);
    la.bit_en = 1'b0;
    step();

    // bit_en alternating, high in the accept cycle: each bit held two cycles.
    exp_a = 8'hA5;
    drive(1'b1, 8'hA5, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      step();
      drive(1'b0, 8'h00, (c % 2 == 0));
      chk($sformatf("alt_dout_c%0d", c), 32'(ma.dout), 32'(exp_a[7-(c-1)/2]));
      chk($sformatf("alt_cnt_c%0d", c), 32'(u_msb.cnt_q), 32'((c - 1) / 2));
    end
    step();
    drive(1'b0, 8'h00, 1'b1);
    chk("alt_done_c17", 32'(ma.frame_done), 32'd1);
    step();

    // Offered word while busy is ignored; accepted when ready at cycle 8.
    drive(1'b1, 8'h00, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      step();
      drive(((c >= 2) && (c <= 5)) || (c == 8), 8'hFF, 1'b1);
      chk($sformatf("ign_dout_c%0d", c), 32'(ma.dout), 32'd0);
      chk($sformatf("ign_ready_c%0d", c), 32'(ma.load_ready), (c == 8) ? 32'd1 : 32'd0);
    end
    step();
    drive(1'b0, 8'h00, 1'b1);
    chk("ign_ff_dout_c9", 32'(ma.dout), 32'd1);
    chk("ign_ff_busy_c9", 32'(ma.busy), 32'd1);
    chk("ign_done_c9", 32'(ma.frame_done), 32'd1);
    for (int c = 10; c <= 17; c++) step();
    chk("ign_ff_done_c17", 32'(ma.frame_done), 32'd1);
    step();

    // Reset in cycle 4 of a 0x99 frame aborts without frame_done.
    drive(1'b1, 8'h99, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      step();
      drive(1'b0, 8'h00, 1'b1);
      if (c == 4) reset = 1'b1;
    end
    step();
    reset = 1'b0;
    #1;
    chk("abort_dout", 32'(ma.dout), 32'd0);
    chk("abort_dvalid", 32'(ma.dout_valid), 32'd0);
    chk("abort_busy", 32'(ma.busy), 32'd0);
    chk("abort_done", 32'(ma.frame_done), 32'd0);
    step();
    chk("abort_ready", 32'(ma.load_ready), 32'd1);
    chk("abort_done_after", 32'(ma.frame_done), 32'd0);
    for (int c = 0; c < 6; c++) step();
    chk("abort_no_late_done", 32'(ma.frame_done), 32'd0);

    // Reset and load_valid together: word is not accepted.
    reset = 1'b1;
    drive(1'b1, 8'hFF, 1'b1);
    step();
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    chk("rst_wins_busy", 32'(ma.busy), 32'd0);
    chk("rst_wins_dvalid", 32'(ma.dout_valid), 32'd0);
    step();
    chk("rst_wins_idle", 32'(ma.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
